ps2_controls: RTL and testbench
===============================

// Module: ps2_controls
// PURPOSE
//  PS/2 keyboard receiver and key-state decoder producing the player1_controls / player2_controls
//  buses consumed by the game module, as the input-side counterpart to the VGA output path.
//  Receives device-to-host PS/2 frames, decodes scan-code set 2 (make, F0 break, E0 extended)
//  and holds one pressed/released bit per mapped key. Runs entirely in the 50 MHz clk domain.
// PARAMETERS
//  CLK_HZ       50_000_000  clk frequency; sets the timeout count
//  TIMEOUT_US   2000        max gap between ps2_clk falling edges inside a frame before abort
//  SYNC_STAGES  2           flops in the ps2_clk / ps2_dat synchronisers (>=2)
// PORTS
//  clk               in   1  system clock, 50 MHz
//  rst_n             in   1  asynchronous, active-low reset
//  ps2_clk           in   1  PS/2 clock from keyboard, async, open-collector (idle 1)
//  ps2_dat           in   1  PS/2 data from keyboard, async
//  player1_controls  out  8  {2'b0, fire, secondary, up, left, right, down}, 1 = held
//  player2_controls  out  8  same layout as player1_controls
//  code_valid        out  1  1-cycle pulse per good received byte
//  code              out  8  last good byte; valid while code_valid is high, held afterwards
//  frame_err         out  1  1-cycle pulse on parity/stop error or timeout
//  debug_led         out  8  only with PS2_DEBUG_EN (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: all outputs 0, receiver IDLE, brk/ext flags 0, timeout counter 0.
//  - Inputs pass through SYNC_STAGES flops; a falling edge = synced prev 1, now 0. ps2_dat sampled on that edge.
//  - Frame: start(0), d0..d7 LSB first, odd parity, stop(1). Bit counter 0..10.
//  - Receiver FSM: IDLE -> (edge, dat=0) RECV. Start bit 1 in IDLE: ignore, stay IDLE, no error.
//    RECV -> on 11th edge: parity odd and stop=1 -> DONE; otherwise frame_err, -> IDLE.
//    DONE -> IDLE after one cycle.
//  - Timeout: counter reloads on every edge; in RECV, CLK_HZ/1e6*TIMEOUT_US cycles without an edge
//    -> frame_err pulse, brk/ext cleared, -> IDLE. The counter does not run in IDLE.
//  - Latency: stop-bit edge detected at cycle N -> code_valid, code, updated controls registered at N+1.
//  - Decode (on each good byte): E0 -> ext=1; F0 -> brk=1 (E0 F0 and F0 alone both valid; repeated F0 stays 1).
//    AA (BAT pass) -> clear both control buses, brk, ext. FA/FE/EE/00/FF -> no effect, flags kept.
//    Otherwise: if {ext,byte} is mapped -> bit <= ~brk; unmapped -> no change; then brk=ext=0.
//  - Map (ext,code) P1: up 0,1D(W)  left 0,1C(A)  right 0,23(D)  down 0,1B(S)  fire 0,2B(F)  sec 0,34(G)
//    P2: up 1,75  left 1,6B  right 1,74  down 1,72  fire 0,5A(Enter)  sec 0,59(RShift)
//    Non-extended 75/6B/74/72 (keypad) are unmapped. Bits [7:6] of both buses tie to 0.
//  - Typematic repeats (repeated make) rewrite 1: idempotent. Any number of keys held simultaneously.
//  - rst_n low mid-frame: immediate abort, all state to reset values; no frame_err.
//  - frame_err and code_valid never assert in the same cycle.
// CONFIGURATION
//  PS2_DEBUG_EN defined: debug_led port present; [7:4] = saturating frame-error count (0..15),
//    [3:0] = low nibble of last good code; both reset to 0.
//  PS2_DEBUG_EN undefined: debug_led port and error counter absent; all other behaviour identical.
// STRUCTURE
//  - Shared include ps2_keys.vh: scan-code localparams (PS2_E0, PS2_F0, PS2_BAT, key codes),
//    control-bus bit indices (CTL_FIRE=5, CTL_SEC=4, CTL_UP=3, CTL_LEFT=2, CTL_RIGHT=1, CTL_DOWN=0).
//    The game module includes the same bit indices.
//  - Sub-module ps2_rx: synchronisers, edge detect, frame FSM, timeout; outputs byte/byte_valid/err.
//    ps2_controls wraps ps2_rx and holds the decode flags and key-state registers.
// TESTING
//  1. Send 1D make -> code_valid once with code=1D; player1_controls=8'h08 at N+1; P2 unchanged.
//  2. Send E0 75, then E0 F0 75 -> player2_controls 8'h08 after first, 8'h00 after; 5 code_valid pulses.
//  3. Send 75 (no E0) -> controls unchanged; code_valid pulses with code=75.
//  4. Frame 2B with even parity -> frame_err pulse, no code_valid, P1 unchanged; debug count=1 if EN.
//  5. Stop ps2_clk after 5 bits for 2.1 ms -> frame_err at timeout; next full frame 1C -> P1=8'h04.
//  6. Hold 1D,1C,2B,5A, send AA -> both buses 0; assert rst_n low mid-frame -> all outputs 0, no frame_err.

Source files
------------

// File: rtl/ps2_controls_pkg.sv
// ============================================================================
//  Module   : ps2_controls_pkg
//  Purpose  : Shared scan-code set 2 constants, control-bus bit indices,
//             receiver state encoding and the key-map lookup function.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package ps2_controls_pkg;

    // Protocol / prefix bytes
    localparam logic [7:0] PS2_E0     = 8'hE0;
    localparam logic [7:0] PS2_F0     = 8'hF0;
    localparam logic [7:0] PS2_BAT    = 8'hAA;
    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_RESEND = 8'hFE;
    localparam logic [7:0] PS2_ECHO   = 8'hEE;
    localparam logic [7:0] PS2_OVF0   = 8'h00;
    localparam logic [7:0] PS2_OVF1   = 8'hFF;

    // Player 1 keys (non-extended)
    localparam logic [7:0] KEY_W      = 8'h1D;
    localparam logic [7:0] KEY_A      = 8'h1C;
    localparam logic [7:0] KEY_D      = 8'h23;
    localparam logic [7:0] KEY_S      = 8'h1B;
    localparam logic [7:0] KEY_F      = 8'h2B;
    localparam logic [7:0] KEY_G      = 8'h34;
    // Player 2 keys: arrows are E0-prefixed, Enter / RShift are not
    localparam logic [7:0] KEY_UP     = 8'h75;
    localparam logic [7:0] KEY_LEFT   = 8'h6B;
    localparam logic [7:0] KEY_RIGHT  = 8'h74;
    localparam logic [7:0] KEY_DOWN   = 8'h72;
    localparam logic [7:0] KEY_ENTER  = 8'h5A;
    localparam logic [7:0] KEY_RSHIFT = 8'h59;

    // Control-bus bit positions, shared with the game module
    localparam logic [2:0] CTL_FIRE   = 3'd5;
    localparam logic [2:0] CTL_SEC    = 3'd4;
    localparam logic [2:0] CTL_UP     = 3'd3;
    localparam logic [2:0] CTL_LEFT   = 3'd2;
    localparam logic [2:0] CTL_RIGHT  = 3'd1;
    localparam logic [2:0] CTL_DOWN   = 3'd0;

    typedef enum logic [1:0] {
        RX_IDLE = 2'd0,
        RX_RECV = 2'd1,
        RX_DONE = 2'd2
    } rx_state_t;

    // Result of a key-map lookup: which bus (if any) and which bit
    typedef struct packed {
        logic       p1;
        logic       p2;
        logic [2:0] idx;
    } key_slot_t;

    function automatic key_slot_t key_lookup(input logic ext, input logic [7:0] code);
        key_slot_t s;
        s = '0;
        case ({ext, code})
            {1'b0, KEY_W}:      begin s.p1 = 1'b1; s.idx = CTL_UP;    end
            {1'b0, KEY_A}:      begin s.p1 = 1'b1; s.idx = CTL_LEFT;  end
            {1'b0, KEY_D}:      begin s.p1 = 1'b1; s.idx = CTL_RIGHT; end
            {1'b0, KEY_S}:      begin s.p1 = 1'b1; s.idx = CTL_DOWN;  end
            {1'b0, KEY_F}:      begin s.p1 = 1'b1; s.idx = CTL_FIRE;  end
            {1'b0, KEY_G}:      begin s.p1 = 1'b1; s.idx = CTL_SEC;   end
            {1'b1, KEY_UP}:     begin s.p2 = 1'b1; s.idx = CTL_UP;    end
            {1'b1, KEY_LEFT}:   begin s.p2 = 1'b1; s.idx = CTL_LEFT;  end
            {1'b1, KEY_RIGHT}:  begin s.p2 = 1'b1; s.idx = CTL_RIGHT; end
            {1'b1, KEY_DOWN}:   begin s.p2 = 1'b1; s.idx = CTL_DOWN;  end
            {1'b0, KEY_ENTER}:  begin s.p2 = 1'b1; s.idx = CTL_FIRE;  end
            {1'b0, KEY_RSHIFT}: begin s.p2 = 1'b1; s.idx = CTL_SEC;   end
            default:            s = '0;
        endcase
        return s;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_rx.sv
// ============================================================================
//  Module   : ps2_rx
//  Purpose  : PS/2 device-to-host frame receiver. Synchronises ps2_clk and
//             ps2_dat, detects falling edges, assembles 11-bit frames and
//             aborts on inter-edge timeout. Result strobes are combinational
//             in the stop-bit edge cycle so the caller can register them.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ps2_rx
    import ps2_controls_pkg::*;
#(
    parameter int CLK_HZ      = 50_000_000,
    parameter int TIMEOUT_US  = 2000,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_err,
    output logic       rx_timeout
);

    localparam int TMO_CYCLES = (CLK_HZ / 1_000_000) * TIMEOUT_US;
    localparam int TMO_W      = $clog2(TMO_CYCLES + 1);

    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_dat_sync;
    logic                   r_clk_prev;
    rx_state_t              r_state;
    logic [3:0]             r_bit_cnt;
    logic [7:0]             r_shift;
    logic                   r_par;
    logic [TMO_W-1:0]       r_tmo;

    logic w_clk_s;
    logic w_dat_s;
    logic w_fall;
    logic w_frame_end;
    logic w_frame_ok;
    logic w_tmo_hit;

    // Synchronisers and edge-detect history; idle level of the bus is 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_sync <= '1;
            r_dat_sync <= '1;
            r_clk_prev <= 1'b1;
        end else begin
            r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
            r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], ps2_dat};
            r_clk_prev <= w_clk_s;
        end
    end

    assign w_clk_s     = r_clk_sync[SYNC_STAGES-1];
    assign w_dat_s     = r_dat_sync[SYNC_STAGES-1];
    assign w_fall      = r_clk_prev & ~w_clk_s;

    // Stop-bit edge: odd parity over data+parity and a high stop bit
    assign w_frame_end = (r_state == RX_RECV) && w_fall && (r_bit_cnt == 4'd10);
    assign w_frame_ok  = w_frame_end && w_dat_s && (^{r_par, r_shift});
    assign w_tmo_hit   = (r_state == RX_RECV) && !w_fall &&
                         (r_tmo == TMO_W'(TMO_CYCLES - 1));

    assign rx_byte     = r_shift;
    assign rx_valid    = w_frame_ok;
    assign rx_err      = (w_frame_end && !w_frame_ok) || w_tmo_hit;
    assign rx_timeout  = w_tmo_hit;

    // Frame FSM with bit counter and inter-edge timeout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= RX_IDLE;
            r_bit_cnt <= 4'd0;
            r_shift   <= 8'h00;
            r_par     <= 1'b0;
            r_tmo     <= '0;
        end else begin
            case (r_state)
                RX_IDLE: begin
                    r_tmo <= '0;
                    // A high start bit is treated as noise and ignored
                    if (w_fall && !w_dat_s) begin
                        r_state   <= RX_RECV;
                        r_bit_cnt <= 4'd1;
                    end
                end
                RX_RECV: begin
                    if (w_fall) begin
                        r_tmo     <= '0;
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                        if (r_bit_cnt <= 4'd8) begin
                            r_shift <= {w_dat_s, r_shift[7:1]};
                        end else if (r_bit_cnt == 4'd9) begin
                            r_par <= w_dat_s;
                        end else begin
                            r_bit_cnt <= 4'd0;
                            r_state   <= w_frame_ok ? RX_DONE : RX_IDLE;
                        end
                    end else if (w_tmo_hit) begin
                        r_tmo     <= '0;
                        r_bit_cnt <= 4'd0;
                        r_state   <= RX_IDLE;
                    end else begin
                        r_tmo <= r_tmo + TMO_W'(1);
                    end
                end
                RX_DONE: begin
                    r_state <= RX_IDLE;
                end
                default: begin
                    r_state <= RX_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/ps2_controls.sv
// ============================================================================
//  Module   : ps2_controls
//  Purpose  : PS/2 keyboard scan-code set 2 decoder producing per-player
//             held-key buses. Wraps ps2_rx; handles E0/F0 prefixes and BAT.
//  Config   : PS2_DEBUG_EN adds debug_led = {sat. error count, code[3:0]}
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ps2_controls
    import ps2_controls_pkg::*;
#(
    parameter int CLK_HZ      = 50_000_000,
    parameter int TIMEOUT_US  = 2000,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] player1_controls,
    output logic [7:0] player2_controls,
    output logic       code_valid,
    output logic [7:0] code,
`ifdef PS2_DEBUG_EN
    output logic [7:0] debug_led,
`endif
    output logic       frame_err
);

    logic [7:0] w_rx_byte;
    logic       w_rx_valid;
    logic       w_rx_err;
    logic       w_rx_timeout;
    key_slot_t  w_slot;

    logic [5:0] r_p1;
    logic [5:0] r_p2;
    logic       r_brk;
    logic       r_ext;
    logic       r_code_valid;
    logic [7:0] r_code;
    logic       r_frame_err;

    ps2_rx #(
        .CLK_HZ      (CLK_HZ),
        .TIMEOUT_US  (TIMEOUT_US),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .ps2_clk    (ps2_clk),
        .ps2_dat    (ps2_dat),
        .rx_byte    (w_rx_byte),
        .rx_valid   (w_rx_valid),
        .rx_err     (w_rx_err),
        .rx_timeout (w_rx_timeout)
    );

    assign w_slot = key_lookup(r_ext, w_rx_byte);

    // Scan-code decode: prefix flags, key-state update and result strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p1         <= 6'd0;
            r_p2         <= 6'd0;
            r_brk        <= 1'b0;
            r_ext        <= 1'b0;
            r_code_valid <= 1'b0;
            r_code       <= 8'h00;
            r_frame_err  <= 1'b0;
        end else begin
            r_code_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            if (w_rx_valid) begin
                r_code_valid <= 1'b1;
                r_code       <= w_rx_byte;
                case (w_rx_byte)
                    PS2_E0: r_ext <= 1'b1;
                    PS2_F0: r_brk <= 1'b1;
                    PS2_BAT: begin
                        // Keyboard self-test pass: nothing can be held any more
                        r_p1  <= 6'd0;
                        r_p2  <= 6'd0;
                        r_brk <= 1'b0;
                        r_ext <= 1'b0;
                    end
                    PS2_ACK, PS2_RESEND, PS2_ECHO, PS2_OVF0, PS2_OVF1: begin
                        // Housekeeping bytes leave prefix flags intact
                    end
                    default: begin
                        if (w_slot.p1) r_p1[w_slot.idx] <= ~r_brk;
                        if (w_slot.p2) r_p2[w_slot.idx] <= ~r_brk;
                        r_brk <= 1'b0;
                        r_ext <= 1'b0;
                    end
                endcase
            end
            if (w_rx_err) begin
                r_frame_err <= 1'b1;
                // A stalled frame means the prefix sequence is no longer trustworthy
                if (w_rx_timeout) begin
                    r_brk <= 1'b0;
                    r_ext <= 1'b0;
                end
            end
        end
    end

    assign player1_controls = {2'b00, r_p1};
    assign player2_controls = {2'b00, r_p2};
    assign code_valid       = r_code_valid;
    assign code             = r_code;
    assign frame_err        = r_frame_err;

`ifdef PS2_DEBUG_EN
    logic [3:0] r_err_cnt;

    // Saturating frame-error counter for the debug LEDs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= 4'd0;
        end else if (r_frame_err && (r_err_cnt != 4'hF)) begin
            r_err_cnt <= r_err_cnt + 4'd1;
        end
    end

    assign debug_led = {r_err_cnt, r_code[3:0]};
`endif

endmodule

`default_nettype wire

// File: tb/tb_ps2_controls.sv
// ============================================================================
//  Module   : tb_ps2_controls
//  Purpose  : Self-checking bench for ps2_controls: directed scenarios plus a
//             randomized byte stream compared against a key-state model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ps2_controls;

    localparam int CLK_HZ     = 50_000_000;
    localparam int TMO_US     = 20;
    localparam int TMO_CYC    = (CLK_HZ / 1_000_000) * TMO_US;
    localparam int HALF       = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic [7:0] p1_out;
    logic [7:0] p2_out;
    logic       code_valid;
    logic [7:0] code;
    logic       frame_err;
`ifdef PS2_DEBUG_EN
    logic [7:0] debug_led;
`endif

    always #10 clk = ~clk;

    ps2_controls #(
        .CLK_HZ      (CLK_HZ),
        .TIMEOUT_US  (TMO_US),
        .SYNC_STAGES (2)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .ps2_clk          (ps2_clk),
        .ps2_dat          (ps2_dat),
        .player1_controls (p1_out),
        .player2_controls (p2_out),
        .code_valid       (code_valid),
        .code             (code),
`ifdef PS2_DEBUG_EN
        .debug_led        (debug_led),
`endif
        .frame_err        (frame_err)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // Output monitor, sampled on the inactive edge
    int         n_valid = 0;
    int         n_err   = 0;
    int         n_overlap = 0;
    logic [7:0] last_code = 8'h00;
    logic [7:0] p1_at_valid = 8'h00;
    logic [7:0] p2_at_valid = 8'h00;

    always @(negedge clk) begin
        if (code_valid) begin
            n_valid++;
            last_code   = code;
            p1_at_valid = p1_out;
            p2_at_valid = p2_out;
        end
        if (frame_err) n_err++;
        if (code_valid && frame_err) n_overlap++;
    end

    // Reference model: held keys per player, prefix flags, debug state
    logic [5:0] m_p1 = 6'd0;
    logic [5:0] m_p2 = 6'd0;
    bit         m_brk = 1'b0;
    bit         m_ext = 1'b0;
    int         m_errs = 0;
    logic [7:0] m_code = 8'h00;

    localparam int NKEY = 12;
    // {ext, code}, player, bit position -- straight from the key map table
    logic [8:0] key_id  [NKEY] = '{9'h01D, 9'h01C, 9'h023, 9'h01B, 9'h02B, 9'h034,
                                   9'h175, 9'h16B, 9'h174, 9'h172, 9'h05A, 9'h059};
    int         key_pl  [NKEY] = '{1, 1, 1, 1, 1, 1, 2, 2, 2, 2, 2, 2};
    int         key_bit [NKEY] = '{3, 2, 1, 0, 5, 4, 3, 2, 1, 0, 5, 4};

    task automatic model_reset();
        m_p1 = 6'd0; m_p2 = 6'd0; m_brk = 1'b0; m_ext = 1'b0;
        m_errs = 0; m_code = 8'h00;
    endtask

    task automatic model_byte(input logic [7:0] b);
        m_code = b;
        if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else if (b == 8'hAA) begin
            m_p1 = 6'd0; m_p2 = 6'd0; m_brk = 1'b0; m_ext = 1'b0;
        end else if (b == 8'hFA || b == 8'hFE || b == 8'hEE || b == 8'h00 || b == 8'hFF) begin
        end else begin
            for (int k = 0; k < NKEY; k++) begin
                if (key_id[k] == {m_ext, b}) begin
                    if (key_pl[k] == 1) m_p1[key_bit[k]] = !m_brk;
                    else                m_p2[key_bit[k]] = !m_brk;
                end
            end
            m_brk = 1'b0;
            m_ext = 1'b0;
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive the first nbits of a frame; bad_par flips the parity bit
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits);
        logic [10:0] bits;
        bits = {1'b1, (~(^b)) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_dat = bits[i];
            wait_cyc(HALF);
            ps2_clk = 1'b0;
            wait_cyc(HALF);
            ps2_clk = 1'b1;
        end
        ps2_dat = 1'b1;
    endtask

    task automatic check_debug();
`ifdef PS2_DEBUG_EN
        logic [3:0] sat;
        sat = (m_errs > 15) ? 4'hF : 4'(m_errs);
        chk("debug_led", {24'd0, debug_led}, {24'd0, sat, m_code[3:0]});
`endif
    endtask

    task automatic do_byte(input logic [7:0] b, input bit bad);
        int v0;
        int e0;
        v0 = n_valid;
        e0 = n_err;
        send_frame(b, bad, 11);
        wait_cyc(8);
        if (bad) m_errs++;
        else     model_byte(b);
        chk("valid_pulses", n_valid - v0, bad ? 0 : 1);
        chk("err_pulses", n_err - e0, bad ? 1 : 0);
        if (!bad) begin
            chk("code", {24'd0, last_code}, {24'd0, b});
            chk("p1_with_valid", {24'd0, p1_at_valid}, {26'd0, m_p1});
            chk("p2_with_valid", {24'd0, p2_at_valid}, {26'd0, m_p2});
        end
        chk("p1", {24'd0, p1_out}, {26'd0, m_p1});
        chk("p2", {24'd0, p2_out}, {26'd0, m_p2});
        check_debug();
    endtask

    logic [7:0] pool [20] = '{8'h1D, 8'h1C, 8'h23, 8'h1B, 8'h2B, 8'h34, 8'h75, 8'h6B,
                              8'h74, 8'h72, 8'h5A, 8'h59, 8'h15, 8'hE0, 8'hF0, 8'hF0,
                              8'hE0, 8'hAA, 8'hFA, 8'hFF};

    initial begin
        int v0;
        int e0;
        // Reset state
        wait_cyc(5);
        chk("rst_p1", {24'd0, p1_out}, 32'd0);
        chk("rst_p2", {24'd0, p2_out}, 32'd0);
        chk("rst_code", {24'd0, code}, 32'd0);
        chk("rst_valid", {31'd0, code_valid}, 32'd0);
        chk("rst_err", {31'd0, frame_err}, 32'd0);
        rst_n = 1'b1;
        wait_cyc(5);
        model_reset();

        // W make
        do_byte(8'h1D, 1'b0);
        chk("t1_p1", {24'd0, p1_out}, 32'h08);

        // Extended up arrow make then break
        v0 = n_valid;
        do_byte(8'hE0, 1'b0);
        do_byte(8'h75, 1'b0);
        chk("t2_p2_make", {24'd0, p2_out}, 32'h08);
        do_byte(8'hE0, 1'b0);
        do_byte(8'hF0, 1'b0);
        do_byte(8'h75, 1'b0);
        chk("t2_p2_break", {24'd0, p2_out}, 32'h00);
        chk("t2_pulses", n_valid - v0, 5);

        // Keypad 8 without E0 is unmapped
        do_byte(8'h75, 1'b0);
        chk("t3_p2", {24'd0, p2_out}, 32'h00);

        // Parity error
        do_byte(8'h2B, 1'b1);

        // High start bit is ignored with no error and no timeout
        e0 = n_err;
        v0 = n_valid;
        ps2_dat = 1'b1;
        wait_cyc(HALF);
        ps2_clk = 1'b0;
        wait_cyc(HALF);
        ps2_clk = 1'b1;
        wait_cyc(TMO_CYC + 200);
        chk("bad_start_err", n_err - e0, 0);
        chk("bad_start_valid", n_valid - v0, 0);

        // Timeout mid-frame after an E0: flags must be dropped
        do_byte(8'hE0, 1'b0);
        e0 = n_err;
        send_frame(8'h1C, 1'b0, 5);
        wait_cyc(TMO_CYC - 100);
        chk("tmo_not_early", n_err - e0, 0);
        wait_cyc(200);
        chk("tmo_fired", n_err - e0, 1);
        m_errs++;
        m_brk = 1'b0;
        m_ext = 1'b0;
        wait_cyc(TMO_CYC + 500);
        chk("tmo_idle_quiet", n_err - e0, 1);
        do_byte(8'h1C, 1'b0);
        chk("t5_p1", {24'd0, p1_out}, 32'h0C);

        // Randomized byte stream
        for (int it = 0; it < 50; it++) begin
            logic [7:0] b;
            bit bad;
            b   = pool[$urandom_range(0, 19)];
            bad = ($urandom_range(0, 9) == 0);
            do_byte(b, bad);
        end

        // Hold several keys then BAT clears both buses
        do_byte(8'h1D, 1'b0);
        do_byte(8'h1C, 1'b0);
        do_byte(8'h2B, 1'b0);
        do_byte(8'h5A, 1'b0);
        do_byte(8'hAA, 1'b0);
        chk("bat_p1", {24'd0, p1_out}, 32'h00);
        chk("bat_p2", {24'd0, p2_out}, 32'h00);

        // Reset in the middle of a frame
        do_byte(8'h23, 1'b0);
        e0 = n_err;
        send_frame(8'h1B, 1'b0, 6);
        rst_n = 1'b0;
        wait_cyc(3);
        model_reset();
        chk("midrst_p1", {24'd0, p1_out}, 32'd0);
        chk("midrst_code", {24'd0, code}, 32'd0);
        check_debug();
        rst_n = 1'b1;
        wait_cyc(TMO_CYC + 300);
        chk("midrst_no_err", n_err - e0, 0);
        do_byte(8'h34, 1'b0);
        chk("post_rst_p1", {24'd0, p1_out}, 32'h10);

        chk("valid_err_overlap", n_overlap, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #10ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
